// File: rtl/pkg_dtypes.sv
// Shared datapath types for the execution unit and its interconnect port.
package pkg_dtypes;

  typedef logic [7:0]  type_exec_unit_addr;
  typedef logic [31:0] type_exec_unit_data;

  // Packet presented to the interconnect by a transmitting execution unit.
  typedef struct packed {
    logic               valid;
    type_exec_unit_addr addr;
    type_exec_unit_data data;
  } type_icon_tx_channel;

  // One storage word of the execution-unit transmit buffer.
  typedef struct packed {
    type_exec_unit_addr addr;
    type_exec_unit_data data;
  } type_txbuf_entry;

  // Transmit buffer fill state, derived from occupancy.
  typedef enum logic [1:0] {
    TXBUF_EMPTY,
    TXBUF_ACTIVE,
    TXBUF_FULL
  } type_txbuf_state;

endpackage

// File: rtl/counter_JK.sv
// Up/down counter: counts up or down by one on each cycle i_trig is high.
module counter_JK #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_trig,
  input  logic             i_inc_or_dec,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count register: synchronous clear, then step up or down when triggered.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_trig) begin
      r_count <= i_inc_or_dec ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/eu_txbuf.sv
// Execution-unit transmit buffer: show-ahead FIFO of ALU results feeding
// the interconnect, with a saturating stall timer on the head entry.
module eu_txbuf
  import pkg_dtypes::*;
#(
  parameter int NUM_IDX_BITS = 2,
  parameter int STALL_LIMIT  = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    alu_wr_valid,
  input  type_exec_unit_addr      alu_wr_addr,
  input  type_exec_unit_data      alu_wr_data,
  output logic                    alu_wr_ready,
  output type_icon_tx_channel     out_pkt,
  input  logic                    out_success,
  output logic [NUM_IDX_BITS:0]   occupancy,
  output logic                    tx_stalled
);

  localparam int                    DEPTH        = 2 ** NUM_IDX_BITS;
  localparam logic [NUM_IDX_BITS:0] OCC_FULL     = (NUM_IDX_BITS + 1)'(DEPTH);
  localparam logic [7:0]            STALL_THRESH = 8'(STALL_LIMIT);

  type_txbuf_entry           r_mem [DEPTH];
  logic [NUM_IDX_BITS-1:0]   r_wptr;
  logic [NUM_IDX_BITS-1:0]   r_rptr;
  logic [7:0]                r_stall_cnt;

  logic [NUM_IDX_BITS:0]     w_occ;
  type_txbuf_state           w_state;
  logic                      w_empty;
  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;
  type_icon_tx_channel       w_pkt;

  // Classify fill state from the registered occupancy.
  always_comb begin
    w_state = TXBUF_ACTIVE;
    if (w_occ == '0) begin
      w_state = TXBUF_EMPTY;
    end else if (w_occ == OCC_FULL) begin
      w_state = TXBUF_FULL;
    end
  end

  assign w_empty      = (w_state == TXBUF_EMPTY);
  assign w_full       = (w_state == TXBUF_FULL);
  // A full buffer refuses writes even when the head leaves this same cycle.
  assign alu_wr_ready = ~w_full;
  assign w_push       = alu_wr_valid & alu_wr_ready;
  assign w_pop        = ~w_empty & out_success;

  counter_JK #(
    .WIDTH (NUM_IDX_BITS + 1)
  ) u_occ_cnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_trig       (w_push ^ w_pop),
    .i_inc_or_dec (w_push),
    .o_count      (w_occ)
  );

  assign occupancy = w_occ;

  // Storage write on push.
  // NOTE: the data array has no reset; only the pointers and occupancy define which words are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{addr: alu_wr_addr, data: alu_wr_data};
    end
  end

  // Read/write pointers advance on pop/push and wrap modulo depth.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Stall timer: counts unaccepted cycles of a valid head, saturating at 255.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_pop || w_empty) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != 8'hFF) begin
      r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

  assign tx_stalled = (r_stall_cnt >= STALL_THRESH);

  // Show-ahead head packet; fields forced to zero while empty.
  // NOTE: defaulting every field first keeps this block free of inferred latches.
  always_comb begin
    w_pkt = '0;
    if (!w_empty) begin
      w_pkt.valid = 1'b1;
      w_pkt.addr  = r_mem[r_rptr].addr;
      w_pkt.data  = r_mem[r_rptr].data;
    end
  end

  assign out_pkt = w_pkt;

endmodule

// File: tb/tb_eu_txbuf.sv
// Directed testbench for eu_txbuf (NUM_IDX_BITS=2, STALL_LIMIT=15).
module tb_eu_txbuf;
  import pkg_dtypes::*;

  logic                clk;
  logic                reset_n;
  logic                alu_wr_valid;
  type_exec_unit_addr  alu_wr_addr;
  type_exec_unit_data  alu_wr_data;
  logic                alu_wr_ready;
  type_icon_tx_channel out_pkt;
  logic                out_success;
  logic [2:0]          occupancy;
  logic                tx_stalled;

  int n_checks = 0;
  int n_errors = 0;

  eu_txbuf #(
    .NUM_IDX_BITS (2),
    .STALL_LIMIT  (15)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_wr_valid (alu_wr_valid),
    .alu_wr_addr  (alu_wr_addr),
    .alu_wr_data  (alu_wr_data),
    .alu_wr_ready (alu_wr_ready),
    .out_pkt      (out_pkt),
    .out_success  (out_success),
    .occupancy    (occupancy),
    .tx_stalled   (tx_stalled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    alu_wr_valid = 1'b0;
    alu_wr_addr  = '0;
    alu_wr_data  = '0;
    out_success  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  function automatic type_icon_tx_channel pkt(input logic v, input logic [7:0] a, input logic [31:0] d);
    pkt = '{valid: v, addr: a, data: d};
  endfunction

  task automatic test_reset();
    type_icon_tx_channel exp;
    do_reset();
    exp = pkt(1'b0, 8'h00, 32'h0);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_pkt !== exp) begin
        n_errors++;
        $display("FAIL reset_pkt cycle %0d got %h expected %h", i, out_pkt, exp);
      end
      n_checks++;
      if (alu_wr_ready !== 1'b1 || occupancy !== 3'd0 || tx_stalled !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_status cycle %0d got ready=%b occ=%0d stalled=%b expected ready=1 occ=0 stalled=0",
                 i, alu_wr_ready, occupancy, tx_stalled);
      end
      step();
    end
  endtask

  task automatic test_single();
    type_icon_tx_channel exp;
    do_reset();
    out_success  = 1'b1;
    alu_wr_valid = 1'b1;
    alu_wr_addr  = 8'd3;
    alu_wr_data  = 32'hA5;
    #1;
    n_checks++;
    if (out_pkt.valid !== 1'b0) begin
      n_errors++;
      $display("FAIL single_no_comb_path got valid=%b expected 0", out_pkt.valid);
    end
    step();
    alu_wr_valid = 1'b0;
    exp = pkt(1'b1, 8'd3, 32'hA5);
    n_checks++;
    if (out_pkt !== exp || occupancy !== 3'd1) begin
      n_errors++;
      $display("FAIL single_latency got pkt=%h occ=%0d expected pkt=%h occ=1", out_pkt, occupancy, exp);
    end
    step();
    n_checks++;
    if (out_pkt.valid !== 1'b0 || occupancy !== 3'd0) begin
      n_errors++;
      $display("FAIL single_pop got valid=%b occ=%0d expected valid=0 occ=0", out_pkt.valid, occupancy);
    end
    out_success = 1'b0;
  endtask

  task automatic test_fill_and_full_pushpop();
    type_icon_tx_channel exp;
    do_reset();
    out_success = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_wr_valid = 1'b1;
      alu_wr_addr  = 8'(i);
      alu_wr_data  = 32'h10 + 32'(i);
      step();
    end
    n_checks++;
    if (occupancy !== 3'd4 || alu_wr_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_full got occ=%0d ready=%b expected occ=4 ready=0", occupancy, alu_wr_ready);
    end
    // Fifth write held by the ALU while full.
    alu_wr_addr = 8'd4;
    alu_wr_data = 32'h14;
    exp = pkt(1'b1, 8'd0, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (occupancy !== 3'd4 || out_pkt !== exp) begin
        n_errors++;
        $display("FAIL full_refuse cycle %0d got occ=%0d pkt=%h expected occ=4 pkt=%h", i, occupancy, out_pkt, exp);
      end
    end
    // Pop while full with a write pending: the write is still refused.
    out_success = 1'b1;
    step();
    out_success = 1'b0;
    exp = pkt(1'b1, 8'd1, 32'h11);
    n_checks++;
    if (occupancy !== 3'd3 || alu_wr_ready !== 1'b1 || out_pkt !== exp) begin
      n_errors++;
      $display("FAIL full_pushpop got occ=%0d ready=%b pkt=%h expected occ=3 ready=1 pkt=%h",
               occupancy, alu_wr_ready, out_pkt, exp);
    end
    // Space is free now: the held write enters.
    step();
    alu_wr_valid = 1'b0;
    n_checks++;
    if (occupancy !== 3'd4) begin
      n_errors++;
      $display("FAIL held_write_enters got occ=%0d expected 4", occupancy);
    end
    // Drain and check order, including the late entry across the pointer wrap.
    out_success = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp = pkt(1'b1, 8'(i), 32'h10 + 32'(i));
      n_checks++;
      if (out_pkt !== exp) begin
        n_errors++;
        $display("FAIL drain_order entry %0d got %h expected %h", i, out_pkt, exp);
      end
      step();
    end
    out_success = 1'b0;
    n_checks++;
    if (out_pkt !== pkt(1'b0, 8'h00, 32'h0) || occupancy !== 3'd0) begin
      n_errors++;
      $display("FAIL drain_empty got pkt=%h occ=%0d expected pkt=0 occ=0", out_pkt, occupancy);
    end
  endtask

  task automatic test_stall();
    type_icon_tx_channel exp;
    do_reset();
    out_success  = 1'b0;
    alu_wr_valid = 1'b1;
    alu_wr_addr  = 8'd7;
    alu_wr_data  = 32'h77;
    step();
    alu_wr_valid = 1'b0;
    exp = pkt(1'b1, 8'd7, 32'h77);
    // 14 waiting edges: still below the limit.
    for (int i = 0; i < 14; i++) step();
    n_checks++;
    if (tx_stalled !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_early got %b expected 0 after 14 waiting cycles", tx_stalled);
    end
    step();
    n_checks++;
    if (tx_stalled !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_rise got %b expected 1 after 15 waiting cycles", tx_stalled);
    end
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (tx_stalled !== 1'b1 || out_pkt !== exp) begin
      n_errors++;
      $display("FAIL stall_hold got stalled=%b pkt=%h expected stalled=1 pkt=%h", tx_stalled, out_pkt, exp);
    end
    out_success = 1'b1;
    step();
    out_success = 1'b0;
    n_checks++;
    if (tx_stalled !== 1'b0 || out_pkt.valid !== 1'b0 || occupancy !== 3'd0) begin
      n_errors++;
      $display("FAIL stall_clear got stalled=%b valid=%b occ=%0d expected stalled=0 valid=0 occ=0",
               tx_stalled, out_pkt.valid, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    type_icon_tx_channel exp;
    do_reset();
    out_success = 1'b1;
    for (int i = 0; i < 20; i++) begin
      alu_wr_valid = 1'b1;
      alu_wr_addr  = 8'(i);
      alu_wr_data  = 32'(i);
      step();
      exp = pkt(1'b1, 8'(i), 32'(i));
      n_checks++;
      if (out_pkt !== exp || occupancy !== 3'd1) begin
        n_errors++;
        $display("FAIL stream item %0d got pkt=%h occ=%0d expected pkt=%h occ=1", i, out_pkt, occupancy, exp);
      end
    end
    // Reset lands while the stream is still running.
    alu_wr_addr = 8'd20;
    alu_wr_data = 32'd20;
    reset_n     = 1'b0;
    step();
    n_checks++;
    if (out_pkt.valid !== 1'b0 || occupancy !== 3'd0) begin
      n_errors++;
      $display("FAIL stream_reset got valid=%b occ=%0d expected valid=0 occ=0", out_pkt.valid, occupancy);
    end
    alu_wr_valid = 1'b0;
    reset_n      = 1'b1;
    step();
    n_checks++;
    if (out_pkt !== pkt(1'b0, 8'h00, 32'h0) || alu_wr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL after_reset got pkt=%h ready=%b expected pkt=0 ready=1", out_pkt, alu_wr_ready);
    end
    out_success = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_and_full_pushpop();
    test_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
